mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).
// - Sits between TopDatapath and the memory model, replacing the separate instruction and data memories.
// - Generates per-requester stall signals consumed by the hazard unit; honours the branch flush pulse.

---
 rtl/mips_arb_pkg.sv | 9 +
 rtl/arb_lat_counter.sv | 17 +
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: state/owner encodings and latency-counter sizing for mem_port_arbiter
package mips_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;
    function automatic int lat_w(input int lat);
        return $clog2(lat + 1);
    endfunction
    localparam int LAT_W = lat_w(1);
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable down-counter timing the memory latency window
module arb_lat_counter #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge Clk)
        if (Reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (!zero) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store
// Optional ARB_PERF_CNT_EN adds stall and conflict performance counters.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall,
    output logic [31:0]       perf_conflict
`endif
);
    localparam int LW = lat_w(MEM_LAT);
    localparam int BW = $clog2(MAX_D_BURST + 1);
    state_t        state;
    owner_t        owner;
    logic [BW-1:0] burst_cnt;
    logic          kill, zero, grant_ok, burst_full, f_gnt, d_gnt;
    // a request whose ack is on the bus this cycle is the one being retired, never a new one
    always_comb begin
        grant_ok   = state == ST_IDLE || state == ST_RESP;
        burst_full = burst_cnt == BW'(MAX_D_BURST);
        f_gnt      = grant_ok && if_req && !if_flush && !if_ack && (!(d_req && !d_ack) || burst_full);
        d_gnt      = grant_ok && d_req && !d_ack && !f_gnt;
    end
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;
    arb_lat_counter #(.W(LW)) u_lat (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (f_gnt || d_gnt),
        .value (LW'(MEM_LAT)),
        .zero  (zero)
    );
    always_ff @(posedge Clk)
        if (Reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            kill      <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            mem_req <= 1'b0;
            if (f_gnt || d_gnt) begin
                state    <= ST_WAIT;
                owner    <= d_gnt ? OWN_DATA : OWN_FETCH;
                kill     <= 1'b0;
                mem_req  <= 1'b1;
                mem_we   <= d_gnt && d_we;
                mem_addr <= d_gnt ? d_addr : if_addr;
                if (d_gnt) mem_wdata <= d_wdata;
            end else if (state == ST_WAIT && zero) begin
                state <= ST_RESP;
                if (owner == OWN_FETCH && !kill && !if_flush) begin
                    if_ack   <= 1'b1;
                    if_rdata <= mem_rdata;
                end
                if (owner == OWN_DATA) begin
                    d_ack <= 1'b1;
                    if (!mem_we) d_rdata <= mem_rdata;
                end
            end else if (state == ST_WAIT) begin
                kill <= kill || (if_flush && owner == OWN_FETCH);
            end else if (state == ST_RESP) begin
                state <= ST_IDLE;
                owner <= OWN_NONE;
            end
        end
    always_ff @(posedge Clk)
        if (Reset || !if_req || f_gnt) burst_cnt <= '0;
        else if (d_gnt && !burst_full) burst_cnt <= burst_cnt + BW'(1);
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge Clk)
        if (Reset) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_conflict <= '0;
        end else begin
            perf_if_stall <= perf_if_stall + {31'd0, if_stall};
            perf_d_stall  <= perf_d_stall + {31'd0, d_stall};
            perf_conflict <= perf_conflict + {31'd0, if_stall & d_stall};
        end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a one-cycle-latency memory model
module tb_mem_port_arbiter;
    import mips_arb_pkg::*;
    logic        Clk, Reset;
    logic        if_req, if_flush, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_d_stall, perf_conflict;
`endif
    logic [31:0] mem [0:255];
    int          n_cmp = 0, n_fail = 0;

    mem_port_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall), .perf_conflict(perf_conflict)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // read-first memory, data valid the cycle after the strobe
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h20020005;
        mem[1]  = 32'h3C011234;
        mem[2]  = 32'hDEADBEEF;
        mem[16] = 32'h8C220040;
        mem[32] = 32'h00000020;
        mem[64] = 32'hCAFEF00D;
        mem_rdata = 32'h0;
        forever begin
            @(posedge Clk);
            if (mem_req) begin
                mem_rdata <= mem[mem_addr[9:2]];
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        tick;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        tick;
        tick;
        @(negedge Clk);
        n_cmp++; if ({if_ack, d_ack, mem_req, mem_we} !== 4'b0) begin n_fail++; $display("FAIL reset strobes got %b want 0000", {if_ack, d_ack, mem_req, mem_we}); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset mem_wdata got %h want 0", mem_wdata); end
        n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset rdata got %h want 0", {if_rdata, d_rdata}); end
        n_cmp++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset state got %0d want %0d", dut.state, ST_IDLE); end
        n_cmp++; if (dut.owner !== OWN_NONE) begin n_fail++; $display("FAIL reset owner got %0d want %0d", dut.owner, OWN_NONE); end
        n_cmp++; if (dut.burst_cnt !== '0) begin n_fail++; $display("FAIL reset burst_cnt got %0d want 0", dut.burst_cnt); end
`ifdef ARB_PERF_CNT_EN
        n_cmp++; if ({perf_if_stall, perf_d_stall, perf_conflict} !== 96'h0) begin n_fail++; $display("FAIL reset perf got %h want 0", {perf_if_stall, perf_d_stall, perf_conflict}); end
`endif
        tick;
    endtask

    task automatic test_fetch;
        logic [5:0] m, ia, da;
        logic [4:0] got, exp;
        m = 6'b000010; ia = 6'b001000; da = 6'b000000;
        do_reset;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin if_req = 1; if_addr = 32'h0; end
            if (c == 4) if_req = 0;
            @(negedge Clk);
            exp = {m[c], ia[c], da[c], if_req & ~ia[c], d_req & ~da[c]};
            got = {mem_req, if_ack, d_ack, if_stall, d_stall};
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL fetch ctl c%0d got %b want %b", c, got, exp); end
            if (c == 1) begin n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch mem_addr got %h want 0", mem_addr); end end
            if (c == 3) begin n_cmp++; if (if_rdata !== 32'h20020005) begin n_fail++; $display("FAIL fetch if_rdata got %h want 20020005", if_rdata); end end
            tick;
        end
    endtask

    task automatic test_contention;
        logic [7:0] m, ia, da;
        logic [4:0] got, exp;
        m = 8'b00010010; ia = 8'b01000000; da = 8'b00001000;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h100; end
            if (c == 4) d_req = 0;
            if (c == 7) if_req = 0;
            @(negedge Clk);
            exp = {m[c], ia[c], da[c], if_req & ~ia[c], d_req & ~da[c]};
            got = {mem_req, if_ack, d_ack, if_stall, d_stall};
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL contention ctl c%0d got %b want %b", c, got, exp); end
            if (c == 1) begin n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 32'h100}) begin n_fail++; $display("FAIL contention load addr got %b/%h want 0/100", mem_we, mem_addr); end end
            if (c == 3) begin n_cmp++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL contention d_rdata got %h want cafef00d", d_rdata); end end
            if (c == 4) begin n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 32'h4}) begin n_fail++; $display("FAIL contention fetch addr got %b/%h want 0/4", mem_we, mem_addr); end end
            if (c == 6) begin n_cmp++; if (if_rdata !== 32'h3C011234) begin n_fail++; $display("FAIL contention if_rdata got %h want 3c011234", if_rdata); end end
`ifdef ARB_PERF_CNT_EN
            if (c == 7) begin
                n_cmp++; if (perf_conflict !== 32'd3) begin n_fail++; $display("FAIL perf_conflict got %0d want 3", perf_conflict); end
                n_cmp++; if (perf_if_stall !== 32'd6) begin n_fail++; $display("FAIL perf_if_stall got %0d want 6", perf_if_stall); end
                n_cmp++; if (perf_d_stall !== 32'd3) begin n_fail++; $display("FAIL perf_d_stall got %0d want 3", perf_d_stall); end
            end
`endif
            tick;
        end
    endtask

    // flush in every data ack cycle keeps fetch out until the burst limit forces it in
    task automatic test_back_to_back;
        logic [20:0] m, ia, da;
        logic [4:0]  got, exp;
        int          k;
        m  = (21'd1 << 1) | (21'd1 << 5) | (21'd1 << 9) | (21'd1 << 13) | (21'd1 << 17) | (21'd1 << 20);
        da = (21'd1 << 3) | (21'd1 << 7) | (21'd1 << 11) | (21'd1 << 15);
        ia = 21'd1 << 19;
        k = 0;
        do_reset;
        for (int c = 0; c < 21; c++) begin
            if (c == 0) begin if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 1; end
            if (c == 4 || c == 8 || c == 12 || c == 16) k++;
            if (c == 20) if_req = 0;
            d_addr = 32'h200 + 32'(4 * k);
            d_wdata = 32'hD0000000 + 32'(k);
            if_flush = (c % 4 == 3) && (c < 16);
            @(negedge Clk);
            exp = {m[c], ia[c], da[c], if_req & ~ia[c], d_req & ~da[c]};
            got = {mem_req, if_ack, d_ack, if_stall, d_stall};
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL burst ctl c%0d got %b want %b", c, got, exp); end
            if (c == 1 || c == 5 || c == 9 || c == 13) begin
                n_cmp++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200 + 32'(c - 1), 32'hD0000000 + 32'((c - 1) / 4)}) begin
                    n_fail++; $display("FAIL burst store c%0d got %b/%h/%h", c, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 16) begin n_cmp++; if (dut.burst_cnt !== 3'd4) begin n_fail++; $display("FAIL burst_cnt full got %0d want 4", dut.burst_cnt); end end
            if (c == 17) begin
                n_cmp++; if (dut.burst_cnt !== 3'd0) begin n_fail++; $display("FAIL burst_cnt clear got %0d want 0", dut.burst_cnt); end
                n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 32'h80}) begin n_fail++; $display("FAIL burst fetch addr got %b/%h want 0/80", mem_we, mem_addr); end
            end
            if (c == 19) begin n_cmp++; if (if_rdata !== 32'h20) begin n_fail++; $display("FAIL burst if_rdata got %h want 20", if_rdata); end end
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[128 + i] !== 32'hD0000000 + 32'(i)) begin n_fail++; $display("FAIL burst mem[%0d] got %h want %h", 128 + i, mem[128 + i], 32'hD0000000 + 32'(i)); end
        end
    endtask

    task automatic test_flush;
        logic [7:0] m, ia, da;
        logic [4:0] got, exp;
        m = 8'b00010010; ia = 8'b01000000; da = 8'b00000000;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin if_req = 1; if_addr = 32'h8; end
            if_flush = c == 1;
            if (c == 2) if_addr = 32'h40;
            if (c == 7) if_req = 0;
            @(negedge Clk);
            exp = {m[c], ia[c], da[c], if_req & ~ia[c], d_req & ~da[c]};
            got = {mem_req, if_ack, d_ack, if_stall, d_stall};
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL flush ctl c%0d got %b want %b", c, got, exp); end
            if (c >= 3 && c <= 5) begin n_cmp++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL flush if_rdata c%0d got %h want 0", c, if_rdata); end end
            if (c == 4) begin n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL flush refetch addr got %h want 40", mem_addr); end end
            if (c == 6) begin n_cmp++; if (if_rdata !== 32'h8C220040) begin n_fail++; $display("FAIL flush refetch data got %h want 8c220040", if_rdata); end end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] m, ia, da;
        logic [4:0] got, exp;
        m = 8'b00010010; ia = 8'b00000000; da = 8'b01000000;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin d_req = 1; d_we = 0; d_addr = 32'h100; end
            Reset = c == 1 || c == 2;
            if (c == 7) d_req = 0;
            @(negedge Clk);
            exp = {m[c], ia[c], da[c], if_req & ~ia[c], d_req & ~da[c]};
            got = {mem_req, if_ack, d_ack, if_stall, d_stall};
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rstmid ctl c%0d got %b want %b", c, got, exp); end
            if (c == 1) begin n_cmp++; if (dut.state !== ST_WAIT) begin n_fail++; $display("FAIL rstmid pre state got %0d want %0d", dut.state, ST_WAIT); end end
            if (c == 2) begin
                n_cmp++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid state got %0d want %0d", dut.state, ST_IDLE); end
                n_cmp++; if ({mem_we, mem_addr, d_rdata} !== 65'h0) begin n_fail++; $display("FAIL rstmid outputs got %b/%h/%h want 0", mem_we, mem_addr, d_rdata); end
            end
            if (c == 4) begin n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL rstmid retry addr got %h want 100", mem_addr); end end
            if (c == 6) begin n_cmp++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rstmid d_rdata got %h want cafef00d", d_rdata); end end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_contention;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
